// File: rtl/diffeq_pkg.sv
// Shared types and constants for the differential-equation solver operand loader.
package diffeq_pkg;

  localparam int unsigned NIB_W_DEFAULT = 4;

  // Operand order on the upstream stream and in the replay buffers.
  localparam logic [1:0] OP_X  = 2'd0;
  localparam logic [1:0] OP_DX = 2'd1;
  localparam logic [1:0] OP_A  = 2'd2;
  localparam logic [1:0] OP_U  = 2'd3;

  typedef enum logic [2:0] {
    R_IDLE  = 3'd0,
    R_CHECK = 3'd1,
    R_LOAD  = 3'd2,
    R_START = 3'd3,
    R_WAIT  = 3'd4
  } rstate_t;

endpackage

// File: rtl/nibble_capture_buf.sv
// Capture side of the operand loader: collects x, dx, a, u nibbles into a staging buffer
// and holds it (s_ready low) until the replay side takes the set with xfer.
module nibble_capture_buf
  import diffeq_pkg::*;
#(
  parameter int unsigned NIB_W = NIB_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  s_valid,
  input  logic [NIB_W-1:0]      s_data,
  output logic                  s_ready,
  input  logic                  xfer,
  output logic                  full,
  output logic [3:0][NIB_W-1:0] cbuf
);

  logic [1:0] cidx_q;
  logic       accept;

  assign s_ready = !full;
  assign accept  = s_valid && s_ready;

  // xfer is only raised while full, when s_ready is low, so it never meets an accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cidx_q <= 2'd0;
      full   <= 1'b0;
      cbuf   <= '0;
    end else if (accept) begin
      cbuf[cidx_q] <= s_data;
      cidx_q       <= cidx_q + 2'd1;
      if (cidx_q == OP_U) begin
        full <= 1'b1;
      end
    end else if (xfer) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/diffeq_operand_loader.sv
// Double-buffered operand loader: replays a captured set onto the datapath in bus with load
// strobes, pulses start, and waits for solver_done. Define DIFFEQ_LOADER_CHECK_EN to reject dx==0.
module diffeq_operand_loader
  import diffeq_pkg::*;
#(
  parameter int unsigned NIB_W = NIB_W_DEFAULT,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             s_valid,
  input  logic [NIB_W-1:0] s_data,
  output logic             s_ready,
  output logic [NIB_W-1:0] dp_in,
  output logic             load_x,
  output logic             load_dx,
  output logic             load_a,
  output logic             load_u,
  output logic             start,
  input  logic             solver_done,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  logic [3:0][NIB_W-1:0] cbuf;
  logic [3:0][NIB_W-1:0] rbuf_q;
  logic                  full;
  logic                  xfer;
  logic                  reject;
  logic                  frame_done;
  rstate_t               rstate_q, rstate_d;
  logic [1:0]            ridx_q, ridx_d;

  nibble_capture_buf #(
    .NIB_W (NIB_W)
  ) u_capture (
    .clk     (clk),
    .reset_n (reset_n),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_ready (s_ready),
    .xfer    (xfer),
    .full    (full),
    .cbuf    (cbuf)
  );

  assign xfer       = full && (rstate_q == R_IDLE);
  assign frame_done = (rstate_q == R_WAIT) && solver_done;

`ifdef DIFFEQ_LOADER_CHECK_EN
  // A zero step would never let the solver reach its end condition.
  assign reject = (rstate_q == R_CHECK) && (rbuf_q[OP_DX] == '0);
`else
  assign reject = 1'b0;
`endif

  always_comb begin
    rstate_d = rstate_q;
    ridx_d   = ridx_q;
    case (rstate_q)
      R_IDLE: begin
        if (xfer) rstate_d = R_CHECK;
      end
      R_CHECK: begin
        if (reject) begin
          rstate_d = R_IDLE;
        end else begin
          rstate_d = R_LOAD;
          ridx_d   = OP_X;
        end
      end
      R_LOAD: begin
        if (ridx_q == OP_U) rstate_d = R_START;
        else                ridx_d   = ridx_q + 2'd1;
      end
      R_START: rstate_d = R_WAIT;
      R_WAIT: begin
        if (solver_done) rstate_d = R_IDLE;
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rstate_q  <= R_IDLE;
      ridx_q    <= 2'd0;
      rbuf_q    <= '0;
      dp_in     <= '0;
      load_x    <= 1'b0;
      load_dx   <= 1'b0;
      load_a    <= 1'b0;
      load_u    <= 1'b0;
      start     <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      rstate_q <= rstate_d;
      ridx_q   <= ridx_d;
      if (xfer) rbuf_q <= cbuf;
      dp_in   <= (rstate_d == R_LOAD) ? rbuf_q[ridx_d] : '0;
      load_x  <= (rstate_d == R_LOAD) && (ridx_d == OP_X);
      load_dx <= (rstate_d == R_LOAD) && (ridx_d == OP_DX);
      load_a  <= (rstate_d == R_LOAD) && (ridx_d == OP_A);
      load_u  <= (rstate_d == R_LOAD) && (ridx_d == OP_U);
      start   <= (rstate_d == R_START);
      busy    <= (rstate_d != R_IDLE);
      err     <= reject;
      if (frame_done) frame_cnt <= frame_cnt + CNT_W'(1);
      if (reject)     drop_cnt  <= drop_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/diffeq_operand_loader.md
# diffeq_operand_loader

Upstream feeder for the differential-equation solver datapath. It accepts operands as a valid/ready stream of 4-bit nibbles in the fixed order x, dx, a, u, and double-buffers each complete set. It then replays the set onto the datapath's shared 4-bit `in` bus with one-hot load strobes, pulses `start` to the controller, and holds until the solver reports done. The next operand set may be collected while the current solve runs.

## Interface
Parameters:
- `NIB_W`, 4: operand nibble width; must match datapath `in`.
- `CNT_W`, 8: width of `frame_cnt` and `drop_cnt`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `s_valid`  in  1  upstream nibble valid.
- `s_data`  in  NIB_W  upstream nibble.
- `s_ready`  out  1  loader can accept a nibble.
- `dp_in`  out  NIB_W  drives datapath `in`.
- `load_x`, `load_dx`, `load_a`, `load_u`  out  1 each  one-hot datapath load strobes.
- `start`  out  1  one-cycle pulse to the controller.
- `solver_done`  in  1  level or pulse from the controller in S_DONE.
- `busy`  out  1  replay side is not idle.
- `err`  out  1  one-cycle pulse when a set is rejected.
- `frame_cnt`  out  CNT_W  completed solves.
- `drop_cnt`  out  CNT_W  rejected sets.

## Operation
Capture side:
- Index `cidx` runs 0..3. A nibble is accepted on an edge where `s_valid && s_ready` and is written to `cbuf[cidx]`.
- On the 4th accept, `full` is set and `cidx` wraps to 0.
- `s_ready = !full`.

Transfer:
- When `full && rstate==R_IDLE`, `cbuf` is copied to `rbuf` and `full` is cleared on the same edge.
- `s_ready` was 0 during that cycle, so a transfer and an accept never coincide.

Replay FSM (`rstate`):
- R_IDLE: waits for a transfer, then goes to R_CHECK.
- R_CHECK: 1 cycle; passes or rejects the set (see Configuration). Pass goes to R_LOAD; reject goes to R_IDLE.
- R_LOAD: 4 cycles, `ridx` 0..3. `dp_in = rbuf[ridx]`. The strobe for `ridx` is high: 0→`load_x`, 1→`load_dx`, 2→`load_a`, 3→`load_u`. Exits to R_START.
- R_START: `start=1` for 1 cycle, `dp_in` = 0, then goes to R_WAIT.
- R_WAIT: waits for `solver_done`, then goes to R_IDLE and increments `frame_cnt`.

Output rules:
- All outputs are registered (Moore).
- Strobes are mutually exclusive; at most one of the four load strobes plus `start` is high in any cycle.
- `dp_in` = 0 whenever no load strobe is high.
- `busy = (rstate != R_IDLE)`.

Boundary conditions:
- `solver_done` is sampled only in R_WAIT; it is ignored in every other state.
- `frame_cnt` and `drop_cnt` wrap from 2^CNT_W−1 to 0.
- Holding `s_valid` high with constant data simply fills the buffer.
- Collection during R_LOAD, R_START or R_WAIT is permitted. A full second set stalls with `s_ready=0` until the replay FSM returns to R_IDLE.
- Reset mid-operation: any partial capture is discarded. `rstate`=R_IDLE, `cidx`=0, `full`=0, buffers and counters are cleared.

Reset values: `s_ready`=1, `dp_in`=0, all strobes=0, `start`=0, `busy`=0, `err`=0, `frame_cnt`=0, `drop_cnt`=0.

## Timing
Cycles are counted from E0, the edge that accepts the 4th nibble, with the replay FSM idle:
- After E1: transfer done; state R_CHECK.
- After E2: `load_x` high.
- After E3: `load_dx` high.
- After E4: `load_a` high.
- After E5: `load_u` high.
- After E6: `start` high.

The first strobe is therefore visible 2 cycles after E0, and `start` 6 cycles after E0.

Other latencies:
- `solver_done` sampled high at edge W: R_IDLE and the updated `frame_cnt` are visible after W.
- If `full` is already 1 at that point, the transfer occurs at W+1.
- Throughput ceiling is one set per 7 cycles plus solve time.
- Upstream can sustain one nibble per cycle.

## Configuration
- `DIFFEQ_LOADER_CHECK_EN` defined: in R_CHECK, a set with `dx == 0` is rejected, because the solver would otherwise loop forever. On reject: `err` pulses for 1 cycle, `drop_cnt` increments, and no strobes or `start` are issued.
- Undefined: R_CHECK always passes, `err` is tied 0 and `drop_cnt` stays 0. R_CHECK still takes 1 cycle, so latency is identical in both builds.

## Structure
- `diffeq_pkg` holds:
  - the `rstate_t` enum (R_IDLE, R_CHECK, R_LOAD, R_START, R_WAIT);
  - operand index constants OP_X=0, OP_DX=1, OP_A=2, OP_U=3;
  - NIB_W default 4.
- Sub-module `nibble_capture_buf` contains the capture side: `cidx`, `cbuf`, `full`, `s_ready`, and the transfer port.
- Top level contains the replay FSM, output registers and counters.

## Test plan
- Reset check: hold `reset_n`=0, then release. All outputs at reset values; `s_ready`=1.
- Single set: stream 2, 1, 6, 3 back-to-back, then pulse `solver_done` 10 cycles after `start`. Required: `load_x`/`dp_in`=2 two cycles after the 4th accept, then dx=1, a=6, u=3 on consecutive cycles, `start` 6 cycles after E0, and `frame_cnt`=1.
- Double buffering: send a second full set during R_WAIT. Required: `s_ready` drops after its 4th nibble, and the second replay begins 2 cycles after `solver_done` is sampled.
- Reject (macro on): send 2, 0, 6, 3. Required: `err` pulses 1 cycle, `drop_cnt`=1, and no strobes or `start`. Macro off: a normal replay occurs.
- Spurious done: assert `solver_done` while in R_IDLE and during R_LOAD. Required: no state change and `frame_cnt` unchanged.
- Reset mid-operation: assert `reset_n`=0 during `load_a`. Required: strobes drop immediately; a partial capture of 2 nibbles is lost, and the next 4 nibbles form a fresh set.
